imsic_msi_receiver: RTL and testbench

- Receiving end of the APLIC MSI delivery path: it accepts single-beat MSI writes from the APLIC domain notifier over a simplified AXI write channel (AW/W/B).
- Decodes the target interrupt file and sets the addressed external-interrupt-pending bit.
- Per file, exposes the pending array, the highest-priority eligible identity (topei) and a hart interrupt line (Xeip). Software claims identities through a claim pulse.
- Sits in front of the per-hart interrupt files, one instance per hart.

---
 rtl/imsic_pkg.sv | 18 +
 rtl/imsic_top_selector.sv | 30 +++
 rtl/imsic_msi_receiver.sv | 147 ++++++++++++++
 tb/tb_imsic_msi_receiver.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imsic_pkg.sv
// Shared types and constants for the IMSIC MSI receiver: transaction FSM states,
// AXI response codes and the interrupt-file register layout.
package imsic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_W  = 3'd1,
        ST_WAIT_AW = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR  = 2'b10;
    localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
    localparam int unsigned FILE_STRIDE      = 4096;

endpackage

// File: rtl/imsic_top_selector.sv
// Threshold-gated priority encoder for one interrupt file: reports the lowest
// pending, enabled identity below the threshold (0 when none).
module imsic_top_selector #(
    parameter int NR_SRC = 64,
    parameter int ID_W   = $clog2(NR_SRC)
) (
    input  logic [NR_SRC-1:0] eip_i,
    input  logic [NR_SRC-1:0] eie_i,
    input  logic [ID_W-1:0]   threshold_i,
    output logic [ID_W-1:0]   topei_o,
    output logic              xeip_o
);

    // Identity 0 is never a candidate, so its pending/enable bits are ignored.
    logic unused_s;
    assign unused_s = eip_i[0] ^ eie_i[0];

    // Descending scan so the lowest eligible identity is the last one written.
    always_comb begin
        topei_o = {ID_W{1'b0}};
        for (int i = NR_SRC - 1; i >= 1; i--) begin
            topei_o = (eip_i[i] && eie_i[i] &&
                       ((threshold_i == {ID_W{1'b0}}) || (ID_W'(i) < threshold_i)))
                      ? ID_W'(i) : topei_o;
        end
    end

    assign xeip_o = (topei_o != {ID_W{1'b0}});

endmodule

// File: rtl/imsic_msi_receiver.sv
// IMSIC MSI receiver: accepts single-beat AXI MSI writes, sets pending bits in
// the addressed interrupt file and presents topei/xeip per file with claim support.
module imsic_msi_receiver
    import imsic_pkg::*;
#(
    parameter int          NR_FILES  = 2,
    parameter int          NR_SRC    = 64,
    parameter int          ID_W      = $clog2(NR_SRC),
    parameter logic [31:0] BASE_ADDR = 32'h2400_0000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_awvalid,
    output logic                       o_awready,
    input  logic [31:0]                i_awaddr,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic [31:0]                i_wdata,
    input  logic [3:0]                 i_wstrb,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    output logic [1:0]                 o_bresp,
    input  logic [NR_FILES*NR_SRC-1:0] i_eie,
    input  logic [NR_FILES*ID_W-1:0]   i_ithreshold,
    input  logic [NR_FILES-1:0]        i_claim,
    output logic [NR_FILES*NR_SRC-1:0] o_eip,
    output logic [NR_FILES*ID_W-1:0]   o_topei,
    output logic [NR_FILES-1:0]        o_xeip
);

    state_e                      state_q, state_d;
    logic                        awready_q, awready_d;
    logic                        wready_q, wready_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 data_q, data_d;
    logic [3:0]                  strb_q, strb_d;
    logic [NR_FILES*NR_SRC-1:0]  eip_q, eip_d;
    logic [NR_FILES*ID_W-1:0]    topei_s;

    logic        aw_hs_s, w_hs_s;
    logic [32:0] win_end_s;
    logic [31:0] off_s;
    logic        in_win_s, set_s;

    assign aw_hs_s   = i_awvalid && awready_q;
    assign w_hs_s    = i_wvalid && wready_q;
    assign win_end_s = 33'(BASE_ADDR) + 33'(NR_FILES * FILE_STRIDE);
    assign off_s     = addr_q - BASE_ADDR;
    assign in_win_s  = (addr_q >= BASE_ADDR) && ({1'b0, addr_q} < win_end_s);
    assign set_s     = (state_q == ST_UPDATE) && in_win_s &&
                       (off_s[11:0] == SETEIPNUM_LE_OFF) && (strb_q == 4'hF) &&
                       (data_q != 32'd0) && (data_q < 32'(NR_SRC));

    // Transaction FSM; ready/valid flags are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        addr_d  = aw_hs_s ? i_awaddr : addr_q;
        data_d  = w_hs_s ? i_wdata : data_q;
        strb_d  = w_hs_s ? i_wstrb : strb_q;
        bresp_d = bresp_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    state_d = ST_UPDATE;
                end else if (aw_hs_s) begin
                    state_d = ST_WAIT_W;
                end else if (w_hs_s) begin
                    state_d = ST_WAIT_AW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_W:  state_d = w_hs_s ? ST_UPDATE : ST_WAIT_W;
            ST_WAIT_AW: state_d = aw_hs_s ? ST_UPDATE : ST_WAIT_AW;
            ST_UPDATE: begin
                state_d = ST_RESP;
                bresp_d = in_win_s ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            ST_RESP:    state_d = i_bready ? ST_IDLE : ST_RESP;
            default:    state_d = ST_IDLE;
        endcase
        awready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_AW);
        wready_d  = (state_d == ST_IDLE) || (state_d == ST_WAIT_W);
        bvalid_d  = (state_d == ST_RESP);
    end

    // Pending-bit update: a set in the UPDATE cycle overrides a same-cycle claim.
    always_comb begin
        eip_d = eip_q;
        for (int f = 0; f < NR_FILES; f++) begin
            for (int i = 1; i < NR_SRC; i++) begin
                eip_d[f*NR_SRC + i] =
                    (set_s && (off_s[31:12] == 20'(f)) && (data_q[ID_W-1:0] == ID_W'(i))) ||
                    (eip_q[f*NR_SRC + i] &&
                     !(i_claim[f] && (topei_s[f*ID_W +: ID_W] == ID_W'(i))));
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            strb_q    <= 4'd0;
            eip_q     <= {(NR_FILES*NR_SRC){1'b0}};
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            eip_q     <= eip_d;
        end
    end

    for (genvar f = 0; f < NR_FILES; f++) begin : g_file
        imsic_top_selector #(
            .NR_SRC (NR_SRC),
            .ID_W   (ID_W)
        ) u_sel (
            .eip_i       (eip_q[f*NR_SRC +: NR_SRC]),
            .eie_i       (i_eie[f*NR_SRC +: NR_SRC]),
            .threshold_i (i_ithreshold[f*ID_W +: ID_W]),
            .topei_o     (topei_s[f*ID_W +: ID_W]),
            .xeip_o      (o_xeip[f])
        );
    end

    assign o_awready = awready_q;
    assign o_wready  = wready_q;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = bresp_q;
    assign o_eip     = eip_q;
    assign o_topei   = topei_s;

endmodule

// File: tb/tb_imsic_msi_receiver.sv
// Directed testbench for imsic_msi_receiver with hand-computed expectations.
module tb_imsic_msi_receiver;

    localparam logic [31:0] BASE = 32'h2400_0000;

    logic         i_clk, i_rst;
    logic         i_awvalid, o_awready, i_wvalid, o_wready, o_bvalid, i_bready;
    logic [31:0]  i_awaddr, i_wdata;
    logic [3:0]   i_wstrb;
    logic [1:0]   o_bresp;
    logic [127:0] i_eie, o_eip;
    logic [11:0]  i_ithreshold, o_topei;
    logic [1:0]   i_claim, o_xeip;

    int tests_run = 0;
    int tests_failed = 0;

    imsic_msi_receiver dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_eie(i_eie), .i_ithreshold(i_ithreshold), .i_claim(i_claim),
        .o_eip(o_eip), .o_topei(o_topei), .o_xeip(o_xeip)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Simultaneous AW+W write from IDLE; waits a bounded time for the response.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit ok);
        ok = 1'b0;
        resp = 2'b11;
        @(negedge i_clk);
        i_awaddr = a; i_wdata = d; i_wstrb = s;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        @(negedge i_clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (o_bvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        if (ok) begin
            resp = o_bresp;
            i_bready = 1'b1;
            @(negedge i_clk);
            i_bready = 1'b0;
        end
    endtask

    task automatic claim_pulse(input logic [1:0] c);
        @(negedge i_clk);
        i_claim = c;
        @(negedge i_clk);
        i_claim = 2'b00;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
        i_awaddr = 32'd0; i_wdata = 32'd0; i_wstrb = 4'd0;
        i_eie = 128'd0; i_ithreshold = 12'd0; i_claim = 2'b00;
        repeat (2) @(negedge i_clk);
        tests_run++;
        if (o_awready !== 1'b0 || o_wready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got aw=%b w=%b expected 0 0", o_awready, o_wready);
        end
        tests_run++;
        if (o_bvalid !== 1'b0 || o_bresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_b: got bvalid=%b bresp=%b expected 0 00", o_bvalid, o_bresp);
        end
        tests_run++;
        if (o_eip !== 128'd0 || o_topei !== 12'd0 || o_xeip !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_eip: got eip=%h topei=%h xeip=%b expected 0", o_eip, o_topei, o_xeip);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if (o_awready !== 1'b1 || o_wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready: got aw=%b w=%b expected 1 1", o_awready, o_wready);
        end
    endtask

    task automatic test_simultaneous();
        i_eie = 128'd0;
        i_eie[5] = 1'b1;
        i_ithreshold = 12'd0;
        @(negedge i_clk);
        i_awaddr = BASE; i_wdata = 32'd5; i_wstrb = 4'hF;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        @(negedge i_clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        tests_run++;
        if (o_bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sim_early_bvalid: got %b expected 0", o_bvalid);
        end
        @(negedge i_clk);
        tests_run++;
        if (o_bvalid !== 1'b1 || o_bresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL sim_resp: got bvalid=%b bresp=%b expected 1 00", o_bvalid, o_bresp);
        end
        tests_run++;
        if (o_eip !== 128'h20 || o_topei[5:0] !== 6'd5 || o_xeip[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sim_set: got eip=%h topei0=%0d xeip0=%b expected eip=20 5 1",
                     o_eip, o_topei[5:0], o_xeip[0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            tests_run++;
            if (o_bvalid !== 1'b1 || o_bresp !== 2'b00) begin
                tests_failed++;
                $display("FAIL sim_hold%0d: got bvalid=%b bresp=%b expected 1 00", k, o_bvalid, o_bresp);
            end
        end
        i_bready = 1'b1;
        @(negedge i_clk);
        i_bready = 1'b0;
        tests_run++;
        if (o_bvalid !== 1'b0 || o_awready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sim_done: got bvalid=%b awready=%b expected 0 1", o_bvalid, o_awready);
        end
    endtask

    task automatic test_aw_first();
        @(negedge i_clk);
        i_awaddr = BASE + 32'h1000;
        i_awvalid = 1'b1;
        @(negedge i_clk);
        i_awvalid = 1'b0;
        tests_run++;
        if (o_awready !== 1'b0 || o_wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL awf_wait: got aw=%b w=%b expected 0 1", o_awready, o_wready);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            tests_run++;
            if (o_wready !== 1'b1 || o_bvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL awf_hold%0d: got wready=%b bvalid=%b expected 1 0", k, o_wready, o_bvalid);
            end
        end
        i_wdata = 32'd7; i_wstrb = 4'hF; i_wvalid = 1'b1;
        @(negedge i_clk);
        i_wvalid = 1'b0;
        tests_run++;
        if (o_wready !== 1'b0) begin
            tests_failed++;
            $display("FAIL awf_wready_drop: got %b expected 0", o_wready);
        end
        @(negedge i_clk);
        tests_run++;
        if (o_bvalid !== 1'b1 || o_bresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL awf_resp: got bvalid=%b bresp=%b expected 1 00", o_bvalid, o_bresp);
        end
        tests_run++;
        if (o_eip[127:64] !== 64'h80 || o_eip[63:0] !== 64'h20) begin
            tests_failed++;
            $display("FAIL awf_eip: got %h expected 0000000000000080_0000000000000020", o_eip);
        end
        i_bready = 1'b1;
        @(negedge i_clk);
        i_bready = 1'b0;
    endtask

    task automatic test_ignored();
        logic [31:0] t_addr [7];
        logic [31:0] t_data [7];
        logic [3:0]  t_strb [7];
        logic [1:0]  t_resp [7];
        logic [1:0]  resp;
        bit          ok;
        t_addr[0] = BASE;             t_data[0] = 32'd0;        t_strb[0] = 4'hF; t_resp[0] = 2'b00;
        t_addr[1] = BASE;             t_data[1] = 32'd64;       t_strb[1] = 4'hF; t_resp[1] = 2'b00;
        t_addr[2] = BASE;             t_data[2] = 32'd9;        t_strb[2] = 4'h3; t_resp[2] = 2'b00;
        t_addr[3] = BASE + 32'h2000;  t_data[3] = 32'd9;        t_strb[3] = 4'hF; t_resp[3] = 2'b10;
        t_addr[4] = BASE + 32'h4;     t_data[4] = 32'd9;        t_strb[4] = 4'hF; t_resp[4] = 2'b00;
        t_addr[5] = BASE;             t_data[5] = 32'h0001_0009; t_strb[5] = 4'hF; t_resp[5] = 2'b00;
        t_addr[6] = BASE - 32'h4;     t_data[6] = 32'd9;        t_strb[6] = 4'hF; t_resp[6] = 2'b10;
        for (int k = 0; k < 7; k++) begin
            axi_write(t_addr[k], t_data[k], t_strb[k], resp, ok);
            tests_run++;
            if (!ok || resp !== t_resp[k]) begin
                tests_failed++;
                $display("FAIL ignored%0d_resp: got ok=%b bresp=%b expected 1 %b", k, ok, resp, t_resp[k]);
            end
            tests_run++;
            if (o_eip[127:64] !== 64'h80 || o_eip[63:0] !== 64'h20) begin
                tests_failed++;
                $display("FAIL ignored%0d_eip: got %h expected eip unchanged", k, o_eip);
            end
        end
    endtask

    task automatic test_priority_claim();
        logic [1:0] resp;
        bit         ok;
        claim_pulse(2'b01);
        tests_run++;
        if (o_eip[63:0] !== 64'd0 || o_topei[5:0] !== 6'd0) begin
            tests_failed++;
            $display("FAIL pc_clear5: got eip0=%h topei0=%0d expected 0 0", o_eip[63:0], o_topei[5:0]);
        end
        axi_write(BASE, 32'd3, 4'hF, resp, ok);
        axi_write(BASE, 32'd9, 4'hF, resp, ok);
        i_eie = 128'd0;
        i_eie[3] = 1'b1;
        i_eie[9] = 1'b1;
        i_ithreshold[5:0] = 6'd5;
        @(negedge i_clk);
        tests_run++;
        if (o_topei[5:0] !== 6'd3 || o_xeip[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pc_thr_top: got topei0=%0d xeip0=%b expected 3 1", o_topei[5:0], o_xeip[0]);
        end
        tests_run++;
        if (o_topei[11:6] !== 6'd0 || o_xeip[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL pc_file1_disabled: got topei1=%0d xeip1=%b expected 0 0", o_topei[11:6], o_xeip[1]);
        end
        claim_pulse(2'b01);
        tests_run++;
        if (o_eip[63:0] !== 64'h200 || o_topei[5:0] !== 6'd0 || o_xeip[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL pc_claim: got eip0=%h topei0=%0d xeip0=%b expected 200 0 0",
                     o_eip[63:0], o_topei[5:0], o_xeip[0]);
        end
        i_ithreshold[5:0] = 6'd0;
        @(negedge i_clk);
        tests_run++;
        if (o_topei[5:0] !== 6'd9 || o_xeip[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pc_nothr: got topei0=%0d xeip0=%b expected 9 1", o_topei[5:0], o_xeip[0]);
        end
    endtask

    task automatic test_claim_vs_set();
        logic [1:0] resp;
        bit         ok;
        claim_pulse(2'b01);
        axi_write(BASE, 32'd4, 4'hF, resp, ok);
        i_eie[4] = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (o_eip[63:0] !== 64'h10 || o_topei[5:0] !== 6'd4) begin
            tests_failed++;
            $display("FAIL cs_setup: got eip0=%h topei0=%0d expected 10 4", o_eip[63:0], o_topei[5:0]);
        end
        i_awaddr = BASE; i_wdata = 32'd4; i_wstrb = 4'hF;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        @(negedge i_clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        i_claim = 2'b01;
        @(negedge i_clk);
        i_claim = 2'b00;
        tests_run++;
        if (o_bvalid !== 1'b1 || o_bresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL cs_resp: got bvalid=%b bresp=%b expected 1 00", o_bvalid, o_bresp);
        end
        tests_run++;
        if (o_eip[4] !== 1'b1 || o_topei[5:0] !== 6'd4) begin
            tests_failed++;
            $display("FAIL cs_set_wins: got eip0[4]=%b topei0=%0d expected 1 4", o_eip[4], o_topei[5:0]);
        end
        i_bready = 1'b1;
        @(negedge i_clk);
        i_bready = 1'b0;
    endtask

    task automatic test_dual_claim();
        i_eie[71] = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (o_topei[11:6] !== 6'd7 || o_xeip !== 2'b11) begin
            tests_failed++;
            $display("FAIL dual_setup: got topei1=%0d xeip=%b expected 7 11", o_topei[11:6], o_xeip);
        end
        claim_pulse(2'b11);
        tests_run++;
        if (o_eip !== 128'd0 || o_xeip !== 2'b00 || o_topei !== 12'd0) begin
            tests_failed++;
            $display("FAIL dual_claim: got eip=%h xeip=%b topei=%h expected 0", o_eip, o_xeip, o_topei);
        end
    endtask

    task automatic test_reset_midtxn();
        logic [1:0] resp;
        bit         ok;
        @(negedge i_clk);
        i_awaddr = BASE; i_wdata = 32'd6; i_wstrb = 4'hF;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        @(negedge i_clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if (o_bvalid !== 1'b1 || o_eip !== 128'h40) begin
            tests_failed++;
            $display("FAIL rst_pre: got bvalid=%b eip=%h expected 1 40", o_bvalid, o_eip);
        end
        i_rst = 1'b1;
        #1;
        tests_run++;
        if (o_bvalid !== 1'b0 || o_eip !== 128'd0 || o_awready !== 1'b0 || o_wready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_abort: got bvalid=%b eip=%h aw=%b w=%b expected 0 0 0 0",
                     o_bvalid, o_eip, o_awready, o_wready);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if (o_awready !== 1'b1 || o_wready !== 1'b1 || o_bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release: got aw=%b w=%b bvalid=%b expected 1 1 0", o_awready, o_wready, o_bvalid);
        end
        axi_write(BASE, 32'd10, 4'hF, resp, ok);
        tests_run++;
        if (!ok || resp !== 2'b00 || o_eip !== 128'h400) begin
            tests_failed++;
            $display("FAIL rst_fresh: got ok=%b bresp=%b eip=%h expected 1 00 400", ok, resp, o_eip);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_aw_first();
        test_ignored();
        test_priority_claim();
        test_claim_vs_set();
        test_dual_claim();
        test_reset_midtxn();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
